// File: rtl/signal_cross_clk_domain_tx_pkg.sv
// Shared definitions for the four-phase event-crossing transmitter and its matching receiver.
package signal_cross_clk_domain_tx_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ_HIGH = 2'd1,
        REQ_LOW  = 2'd2
    } hs_state_t;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_CNT_WIDTH   = 4;

endpackage

// File: rtl/signal_cross_clk_domain_tx_level_sync_chain.sv
// N-flop level synchronizer; every stage clears to 0 on asynchronous active-low reset.
module level_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/signal_cross_clk_domain_tx.sv
// Source side of a four-phase req/ack event crossing: counts strobes on signal_in and
// launches one handshake per counted event towards the destination clock domain.
module signal_cross_clk_domain_tx
    import signal_cross_clk_domain_tx_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 signal_in,
    output logic                 req_out,
    input  logic                 ack_in,
    output logic [CNT_WIDTH-1:0] pending,
    output logic                 busy,
    output logic                 overflow,
    output logic [1:0]           fsm_state
);

    localparam logic [CNT_WIDTH-1:0] PEND_MAX = '1;

    hs_state_t            state;
    hs_state_t            state_next;
    logic                 ack_s;
    logic                 launch;
    logic                 full;
    logic                 accept;
    logic [CNT_WIDTH-1:0] pending_next;

    level_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ack_in),
        .q     (ack_s)
    );

    // Handshake: req rises only from IDLE with ack_s low (a stale ack can never
    // complete a new request), then req holds until ack_s is seen high, and the
    // next launch waits until ack_s has returned low.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        unique case (state)
            IDLE: begin
                if ((pending != '0) && !ack_s) begin
                    state_next = REQ_HIGH;
                    launch     = 1'b1;
                end
            end
            REQ_HIGH: begin
                if (ack_s) begin
                    state_next = REQ_LOW;
                end
            end
            REQ_LOW: begin
                if (!ack_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A launch frees a slot this cycle, so a strobe arriving against a full counter is still accepted.
    assign full   = (pending == PEND_MAX);
    assign accept = signal_in && (!full || launch);

    always_comb begin
        pending_next = pending;
        if (accept && !launch) begin
            pending_next = pending + 1'b1;
        end else if (launch && !accept) begin
            pending_next = pending - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            req_out  <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            pending  <= pending_next;
            req_out  <= (state_next == REQ_HIGH);
            busy     <= (state_next != IDLE);
            overflow <= signal_in && full && !launch;
        end
    end

    assign fsm_state = state;

endmodule
